// File: rtl/mcr_nvram_bridge.sv
`default_nettype none
// mcr_nvram_bridge: hps_io ioctl <-> game NVRAM sideband bridge (download/upload with wait handshake).
// Define NVRAM_AUTOSAVE_EN to add CPU-write snooping and the idle-timed save_req.
module mcr_nvram_bridge #(
  parameter int         AW       = 10,
  parameter int         RD_LAT   = 2,
  parameter logic [7:0] NV_INDEX = 8'd4,
  parameter int         IDLE_CYC = 40_000_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_upload,
  input  logic          ioctl_wr,
  input  logic          ioctl_rd,
  input  logic [7:0]    ioctl_index,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic [AW-1:0] nv_addr,
  output logic          nv_we,
  output logic [7:0]    nv_wdata,
  input  logic [7:0]    nv_rdata,
  input  logic          cpu_nv_we,
  output logic          save_req,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_DL, S_UL, S_UL_RD} state_t;

  state_t     state;
  logic [2:0] lat_cnt;
  logic       rd_oor;
  logic       sel;
  logic       in_rng;

  assign sel    = (ioctl_index == NV_INDEX);
  assign in_rng = (ioctl_addr[24:AW] == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      nv_addr    <= '0;
      nv_we      <= 1'b0;
      nv_wdata   <= 8'h00;
      busy       <= 1'b0;
      lat_cnt    <= 3'd0;
      rd_oor     <= 1'b0;
    end else begin
      nv_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel && ioctl_download) begin
            state <= S_DL;
            busy  <= 1'b1;
          end else if (sel && ioctl_upload) begin
            state <= S_UL;
            busy  <= 1'b1;
          end
        end
        S_DL: begin
          if (!ioctl_download) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (ioctl_wr && in_rng) begin
            nv_addr  <= ioctl_addr[AW-1:0];
            nv_wdata <= ioctl_dout;
            nv_we    <= 1'b1;
          end
        end
        S_UL: begin
          if (!ioctl_upload) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (ioctl_rd) begin
            nv_addr    <= ioctl_addr[AW-1:0];
            rd_oor     <= !in_rng;
            ioctl_wait <= 1'b1;
            lat_cnt    <= 3'(RD_LAT);
            state      <= S_UL_RD;
          end
        end
        S_UL_RD: begin
          if (!ioctl_upload) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            ioctl_wait <= 1'b0;
          end else if (lat_cnt == 3'd0) begin
            // Out-of-range reads return erased-flash style 0xFF instead of aliased NVRAM.
            ioctl_din  <= rd_oor ? 8'hFF : nv_rdata;
            ioctl_wait <= 1'b0;
            state      <= S_UL;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef NVRAM_AUTOSAVE_EN
  localparam int            CW  = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam logic [CW-1:0] SAT = CW'(IDLE_CYC - 1);

  logic          dirty;
  logic [CW-1:0] idle_cnt;
  logic          xfer_done;

  assign xfer_done = ((state == S_DL) && !ioctl_download) ||
                     (((state == S_UL) || (state == S_UL_RD)) && !ioctl_upload);

  // A CPU write landing on the same cycle a transfer completes keeps the data dirty.
  always_ff @(posedge clk) begin
    if (reset) begin
      dirty    <= 1'b0;
      idle_cnt <= '0;
    end else if (cpu_nv_we) begin
      dirty    <= 1'b1;
      idle_cnt <= '0;
    end else if (xfer_done) begin
      dirty    <= 1'b0;
      idle_cnt <= '0;
    end else if (dirty && !busy && (idle_cnt != SAT)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign save_req = dirty && (idle_cnt == SAT);
`else
  logic unused_snoop;
  assign unused_snoop = cpu_nv_we;
  assign save_req     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mcr_nvram_bridge.sv
`default_nettype none
// tb_mcr_nvram_bridge: scoreboard bench for mcr_nvram_bridge (AW=10, RD_LAT=2, IDLE_CYC=16).
module tb_mcr_nvram_bridge;
  localparam int AW       = 10;
  localparam int RD_LAT   = 2;
  localparam int IDLE_CYC = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_upload = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic          ioctl_rd = 1'b0;
  logic [7:0]    ioctl_index = 8'd0;
  logic [24:0]   ioctl_addr = 25'd0;
  logic [7:0]    ioctl_dout = 8'd0;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic [AW-1:0] nv_addr;
  logic          nv_we;
  logic [7:0]    nv_wdata;
  logic [7:0]    nv_rdata;
  logic          cpu_nv_we = 1'b0;
  logic          save_req;
  logic          busy;

  always #5 clk = ~clk;

  mcr_nvram_bridge #(
    .AW(AW), .RD_LAT(RD_LAT), .NV_INDEX(8'd4), .IDLE_CYC(IDLE_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .nv_addr(nv_addr), .nv_we(nv_we),
    .nv_wdata(nv_wdata), .nv_rdata(nv_rdata), .cpu_nv_we(cpu_nv_we),
    .save_req(save_req), .busy(busy)
  );

  // NVRAM model: two-cycle read pipeline returning addr ^ 0x3C.
  logic [7:0] rd_p1 = 8'd0, rd_p2 = 8'd0;
  always @(posedge clk) begin
    rd_p1 <= nv_addr[7:0] ^ 8'h3C;
    rd_p2 <= rd_p1;
  end
  assign nv_rdata = rd_p2;

  int n_checks = 0;
  int n_fail = 0;
  int unexp_we = 0;
  logic [17:0] wr_q[$];
  logic [7:0]  rd_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && nv_we) begin
      if (wr_q.size() == 0) unexp_we++;
      else check_val("nv_write", {14'd0, nv_addr, nv_wdata}, {14'd0, wr_q.pop_front()});
    end
  end

  task automatic dl_start(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic dl_byte(input logic [24:0] a, input logic [7:0] d, input logic exp_busy);
    check_val("busy_dl", {31'd0, busy}, {31'd0, exp_busy});
    if (ioctl_index == 8'd4 && a[24:AW] == '0) wr_q.push_back({a[AW-1:0], d});
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    @(posedge clk); #1 ioctl_wr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic dl_end();
    ioctl_download = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("busy_after_dl", {31'd0, busy}, 32'd0);
  endtask

  task automatic ul_start();
    ioctl_index = 8'd4;
    ioctl_upload = 1'b1;
    @(posedge clk); #1;
    check_val("busy_ul", {31'd0, busy}, 32'd1);
  endtask

  task automatic ul_read(input logic [24:0] a);
    logic [7:0] exp_din;
    int wc;
    exp_din = (a[24:AW] == '0) ? (a[7:0] ^ 8'h3C) : 8'hFF;
    rd_q.push_back(exp_din);
    ioctl_addr = a;
    ioctl_rd = 1'b1;
    @(posedge clk); #1 ioctl_rd = 1'b0;
    wc = 0;
    @(negedge clk);
    while (ioctl_wait && wc < 50) begin
      wc++;
      @(negedge clk);
    end
    check_val("ul_wait_cycles", wc, RD_LAT + 1);
    check_val("ul_din", {24'd0, ioctl_din}, {24'd0, rd_q.pop_front()});
    @(posedge clk); #1;
  endtask

  task automatic ul_end();
    ioctl_upload = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("busy_after_ul", {31'd0, busy}, 32'd0);
    check_val("save_req_after_ul", {31'd0, save_req}, 32'd0);
  endtask

  task automatic pulse_cpu_we();
    cpu_nv_we = 1'b1;
    @(posedge clk); #1 cpu_nv_we = 1'b0;
  endtask

  task automatic count_quiet(output int n);
    n = 0;
    @(negedge clk);
    while (!save_req && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int q;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_din", {24'd0, ioctl_din}, 32'd0);
    check_val("rst_wait", {31'd0, ioctl_wait}, 32'd0);
    check_val("rst_nv", {13'd0, nv_addr, nv_we, nv_wdata}, 32'd0);
    check_val("rst_save_busy", {30'd0, save_req, busy}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Index 4 download of four bytes, then out-of-range and foreign-index writes.
    dl_start(8'd4);
    dl_byte(25'd0, 8'hA5, 1'b1);
    dl_byte(25'd1, 8'h5A, 1'b1);
    dl_byte(25'd2, 8'h00, 1'b1);
    dl_byte(25'd3, 8'hFF, 1'b1);
    dl_byte(25'h400, 8'h77, 1'b1);
    dl_end();
    dl_start(8'd0);
    dl_byte(25'd1, 8'h11, 1'b0);
    dl_byte(25'd2, 8'h22, 1'b0);
    dl_end();
    check_val("unexpected_nv_we", unexp_we, 32'd0);

    ul_start();
    ul_read(25'd7);
    ul_read(25'h7FF);
    ul_read(25'h3C5);
    ul_end();

`ifdef NVRAM_AUTOSAVE_EN
    pulse_cpu_we();
    count_quiet(q);
    check_val("autosave_quiet", q, IDLE_CYC - 1);
    check_val("save_req_high", {31'd0, save_req}, 32'd1);
    ul_start();
    ul_end();
    pulse_cpu_we();
    repeat (7) @(posedge clk);
    #1;
    check_val("save_req_early", {31'd0, save_req}, 32'd0);
    pulse_cpu_we();
    count_quiet(q);
    check_val("autosave_retrigger", q, IDLE_CYC - 1);
`else
    pulse_cpu_we();
    repeat (IDLE_CYC + 4) @(posedge clk);
    #1;
    check_val("save_req_disabled", {31'd0, save_req}, 32'd0);
`endif

    // Reset in the middle of a pending upload read.
    ul_start();
    ioctl_addr = 25'd5;
    ioctl_rd = 1'b1;
    @(posedge clk); #1 ioctl_rd = 1'b0;
    @(posedge clk); #1;
    check_val("wait_before_rst", {31'd0, ioctl_wait}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("rst_mid_wait", {31'd0, ioctl_wait}, 32'd0);
    check_val("rst_mid_din", {24'd0, ioctl_din}, 32'd0);
    check_val("rst_mid_busy_save", {30'd0, busy, save_req}, 32'd0);
    ioctl_upload = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    check_val("idle_after_rst", {31'd0, busy}, 32'd0);

    check_val("wr_q_drained", wr_q.size(), 32'd0);
    check_val("rd_q_drained", rd_q.size(), 32'd0);
    check_val("unexpected_nv_we_end", unexp_we, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
